// File: rtl/io_port_if.sv
// Bus bundle for io_port: core OUT/IN strobes plus both external valid/ready channels.
// The design binds to the slave modport, the core/board side drives through master.
interface io_port_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // OUT path: core push side and external drain side
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_full;
  logic [CNT_W-1:0]  out_count;
  logic              out_overflow;
  logic              ovf_clr;
  logic              ext_out_valid;
  logic [DATA_W-1:0] ext_out_data;
  logic              ext_out_ready;

  // IN path: external producer side and core read side
  logic              in_read;
  logic [DATA_W-1:0] in_data;
  logic              in_avail;
  logic              in_underflow;
  logic              ext_in_valid;
  logic [DATA_W-1:0] ext_in_data;
  logic              ext_in_ready;

  modport slave (
    input  out_valid, out_data, ovf_clr, ext_out_ready,
    input  in_read, ext_in_valid, ext_in_data,
    output out_full, out_count, out_overflow, ext_out_valid, ext_out_data,
    output in_data, in_avail, in_underflow, ext_in_ready
  );

  modport master (
    output out_valid, out_data, ovf_clr, ext_out_ready,
    output in_read, ext_in_valid, ext_in_data,
    input  out_full, out_count, out_overflow, ext_out_valid, ext_out_data,
    input  in_data, in_avail, in_underflow, ext_in_ready
  );
endinterface

// File: rtl/io_port.sv
// Peripheral responder for the core's OUT/IN instructions: an output FIFO drained over
// valid/ready, and a single-word input holding register filled over valid/ready.
module io_port #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  io_port_if.slave   bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  // ---------------- output FIFO ----------------
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_r;
  logic              valid_r;
  logic              ovf_r;
  logic              push_c;
  logic              pop_c;
  logic              ovf_set_c;

  // Full is the registered start-of-cycle value, so a pop never makes room for a same-cycle push.
  assign push_c    = bus.out_valid & ~full_r;
  assign pop_c     = valid_r & bus.ext_out_ready;
  assign ovf_set_c = bus.out_valid & full_r;

  always_comb begin
    count_nxt = count;
    unique case ({push_c, pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Count is authoritative for empty/full; pointers wrap freely on the power-of-2 depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      full_r  <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_nxt;
      full_r  <= (count_nxt == CNT_W'(DEPTH));
      valid_r <= (count_nxt != '0);
    end
  end

  // Storage array carries no reset; only slots behind valid pointers are ever observed.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= bus.out_data;
  end

  // Sticky drop flag; a new drop in the clear cycle keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         ovf_r <= 1'b0;
    else if (ovf_set_c) ovf_r <= 1'b1;
    else if (bus.ovf_clr) ovf_r <= 1'b0;
  end

  assign bus.out_full      = full_r;
  assign bus.out_count     = count;
  assign bus.out_overflow  = ovf_r;
  assign bus.ext_out_valid = valid_r;
  assign bus.ext_out_data  = valid_r ? mem[rd_ptr] : '0;

  // ---------------- input holding register ----------------
  logic              avail_r;
  logic              avail_nxt;
  logic [DATA_W-1:0] in_data_r;
  logic [DATA_W-1:0] in_data_nxt;
  logic              udf_r;
  logic              udf_nxt;
  logic              in_ready_r;
  logic              accept_c;

  assign accept_c = bus.ext_in_valid & in_ready_r;

  // Next-state for the holding register; in_data holds through the consuming read.
  always_comb begin
    avail_nxt   = avail_r;
    in_data_nxt = in_data_r;
    udf_nxt     = udf_r;
    if (accept_c) begin
      avail_nxt   = 1'b1;
      in_data_nxt = bus.ext_in_data;
    end else if (bus.in_read) begin
      avail_nxt   = 1'b0;
    end
    if (bus.in_read & ~avail_r) udf_nxt = 1'b1;
    else if (bus.ovf_clr)       udf_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      avail_r    <= 1'b0;
      in_data_r  <= '0;
      udf_r      <= 1'b0;
      in_ready_r <= 1'b1;
    end else begin
      avail_r    <= avail_nxt;
      in_data_r  <= in_data_nxt;
      udf_r      <= udf_nxt;
      in_ready_r <= ~avail_nxt;
    end
  end

  assign bus.in_data      = in_data_r;
  assign bus.in_avail     = avail_r;
  assign bus.in_underflow = udf_r;
  assign bus.ext_in_ready = in_ready_r;

endmodule

// File: doc/io_port.md
Name: io_port

Overview:
- Peripheral-side responder for the MCU core's OUT and IN instructions.
- OUT path: the core's one-cycle `out_valid` strobe pushes the 16-bit operand into an output FIFO. The FIFO drains to an external consumer over a valid/ready handshake.
- IN path: an external producer deposits one word into a holding register over valid/ready. The core consumes it with a one-cycle `in_read` strobe while executing IN.
- Sits between the control unit/register file and the board-level I/O pins.

Parameters:
- DATA_W, 16, width of every data word.
- DEPTH, 4, output FIFO entries; must be a power of 2 and >= 2.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- out_valid  input  1  core OUT strobe; one push request per cycle high.
- out_data  input  DATA_W  word to push.
- out_full  output  1  FIFO holds DEPTH entries.
- out_count  output  $clog2(DEPTH)+1  current FIFO occupancy.
- out_overflow  output  1  sticky: a push was dropped.
- ovf_clr  input  1  clears out_overflow.
- ext_out_valid  output  1  FIFO head is valid.
- ext_out_data  output  DATA_W  FIFO head word.
- ext_out_ready  input  1  external consumer accepts head.
- in_read  input  1  core IN strobe.
- in_data  output  DATA_W  holding-register contents.
- in_avail  output  1  holding register holds an unread word.
- in_underflow  output  1  sticky: in_read seen while in_avail=0; cleared by ovf_clr.
- ext_in_valid  input  1  external word offered.
- ext_in_data  input  DATA_W  offered word.
- ext_in_ready  output  1  holding register can accept.

Behaviour:
- Reset (async assert, sync-released by the system):
  - rd/wr pointers=0, count=0, out_full=0, ext_out_valid=0.
  - out_overflow=0, in_avail=0, in_data=0, in_underflow=0, ext_in_ready=1.
- Output FIFO:
  - Circular buffer of DEPTH x DATA_W, with registered pointers and registered count.
  - `out_full = (count==DEPTH)`; `ext_out_valid = (count!=0)`.
  - `ext_out_data = mem[rd_ptr]` when count!=0, else 0 (never X).
- Push and pop conditions:
  - push = out_valid & ~out_full, where out_full is the value at the start of the cycle. The word is written at mem[wr_ptr], and wr_ptr increments modulo DEPTH.
  - pop = ext_out_valid & ext_out_ready. rd_ptr increments modulo DEPTH.
  - Push and pop in the same cycle: both pointers advance and count is unchanged.
  - count +1 on push only, -1 on pop only.
- FIFO boundary conditions:
  - When full, out_valid is dropped and out_overflow sets on the next edge. This applies even if a pop occurs that cycle: there is no full-bypass.
  - Push into empty: ext_out_valid=1 and ext_out_data=pushed word on the cycle after the push edge (latency 1).
  - Pop of the last entry returns ext_out_valid to 0 next cycle.
  - Empty and full are both reachable after wrap-around; pointer wrap must not alias them, because count is authoritative.
- out_overflow:
  - Sticky until ovf_clr.
  - ovf_clr and a new overflow in the same cycle: the flag stays 1 (set wins).
- Input holding register:
  - `ext_in_ready = ~in_avail` (registered state, no combinational path from in_read).
  - Accept = ext_in_valid & ext_in_ready: in_data <= ext_in_data and in_avail <= 1.
  - in_read with in_avail=1: in_avail <= 0. in_data holds its value so the core samples it in the same cycle as in_read.
  - in_read with in_avail=0: in_data unchanged, in_underflow sets; sticky, with the same set-wins rule for ovf_clr.
  - Because ext_in_ready is low while in_avail=1, a new word can land at the earliest one cycle after the consuming in_read. Maximum throughput is 1 word per 2 cycles.
- Reset mid-operation: FIFO contents are discarded (pointers and count zeroed); the holding register is cleared immediately.
- No state other than mem depends on clk without reset. mem itself is not reset.

Test Plan:
- Reset, then 4 out_valid pushes 0x1111..0x4444 with ext_out_ready=0 -> out_full=1, out_count=4; 5th push 0x5555 -> dropped, out_overflow=1, count stays 4.
- Then ext_out_ready=1 for 4 cycles -> ext_out_data sequence 0x1111,0x2222,0x3333,0x4444; then ext_out_valid=0, ext_out_data=0; ovf_clr -> out_overflow=0.
- 10 cycles of simultaneous push (values 0xA000+i) and ready=1 with count held at 2 -> count stays 2, order preserved through pointer wrap.
- ext_in_valid=1 with 0xBEEF -> next cycle in_avail=1, ext_in_ready=0, in_data=0xBEEF. Offer 0xCAFE -> not taken. in_read -> in_avail=0 next cycle; 0xCAFE is taken one cycle after that.
- in_read with in_avail=0 -> in_underflow=1, in_data unchanged. ovf_clr and in_read together -> in_underflow stays 1.
- Assert rst_n=0 with 3 FIFO entries and in_avail=1 -> immediately out_count=0, ext_out_valid=0, in_avail=0, ext_in_ready=1.
